// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared definitions for the multiply/divide sequencing
// controller and the HI/LO datapath it drives.
//   - MDU op codes as seen in the E stage (MD_NONE .. MD_MFLO)
//   - calc_op encodings for the in-flight calculation
//   - default latencies and counter width
//   - controller state encoding
package md_ctrl_pkg;

  typedef logic [3:0] md_op_t;
  typedef logic [1:0] calc_op_t;

  // E-stage MDU op codes; anything above MD_MFLO is treated as none.
  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MTHI  = 4'd5;
  localparam md_op_t MD_MTLO  = 4'd6;
  localparam md_op_t MD_MFHI  = 4'd7;
  localparam md_op_t MD_MFLO  = 4'd8;

  // In-flight calculation encodings (E op code minus one).
  localparam calc_op_t CALC_MULT  = 2'd0;
  localparam calc_op_t CALC_MULTU = 2'd1;
  localparam calc_op_t CALC_DIV   = 2'd2;
  localparam calc_op_t CALC_DIVU  = 2'd3;

  // Default latencies shared with the MDU datapath.
  localparam int MD_MULT_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF  = 10;
  localparam int MD_CNT_W_DEF    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // True for the four ops that start a multi-cycle calculation.
  function automatic logic is_calc_op(input md_op_t op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // True for the two divide ops (they load the longer latency).
  function automatic logic is_div_op(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// md_ctrl_if: pipeline <-> MDU controller signal bundle.
//   master (pipeline side): drives Req, E_md_op, D_md_use; observes enables/stall.
//   slave  (md_ctrl):       consumes requests; drives cap_en, calc_op, hl_we,
//                           hi_mt_we, lo_mt_we, busy, D_stall.
// Handshake: E_md_op in {mult,multu,div,divu} is the request ("valid"); the
// controller is "ready" only in IDLE with Req low, and the transfer happens in
// the cycle where both hold, which is exactly the cycle cap_en is high. There
// is no back-pressure path other than D_stall, which keeps new MDU ops out of E
// while a calculation is in flight.
interface md_ctrl_if;
  logic                  Req;
  md_ctrl_pkg::md_op_t   E_md_op;
  logic                  D_md_use;
  logic                  cap_en;
  md_ctrl_pkg::calc_op_t calc_op;
  logic                  hl_we;
  logic                  hi_mt_we;
  logic                  lo_mt_we;
  logic                  busy;
  logic                  D_stall;

  modport master (
    output Req, E_md_op, D_md_use,
    input  cap_en, calc_op, hl_we, hi_mt_we, lo_mt_we, busy, D_stall
  );

  modport slave (
    input  Req, E_md_op, D_md_use,
    output cap_en, calc_op, hl_we, hi_mt_we, lo_mt_we, busy, D_stall
  );
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: sequencing controller for the multiply/divide unit behind the
// E-stage HI/LO path.
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   md         md_ctrl_if.slave bundle:
//                Req       exception taken; E-stage instruction is flushed
//                E_md_op   E-stage MDU op code
//                D_md_use  D-stage instruction is an MDU op
//                cap_en    (comb) capture operands into MDU this cycle
//                calc_op   (reg) op of the in-flight calculation
//                hl_we     (reg) one-cycle pulse: write computed HI/LO
//                hi_mt_we  (comb) mthi write of E_rs into HI
//                lo_mt_we  (comb) mtlo write of E_rs into LO
//                busy      (reg) calculation in flight
//                D_stall   (comb) stall the D stage
//   state_dbg  current FSM state
//   cnt_dbg    current latency counter value
// An op accepted in cycle t keeps busy high for cycles t+1..t+LAT and pulses
// hl_we in cycle t+LAT+1.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT_DEF,
  parameter int DIV_LAT  = MD_DIV_LAT_DEF,
  parameter int CNT_W    = MD_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  md_ctrl_if.slave         md,
  output md_state_e        state_dbg,
  output logic [CNT_W-1:0] cnt_dbg
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  calc_op_t         calc_op_q, calc_op_d;
  logic             hl_we_q, hl_we_d;

  logic             accept;
  logic             hi_we, lo_we;

  // Next-state and combinational outputs. Requests only take effect in IDLE;
  // anything arriving while BUSY is dropped (no restart, no mt write), which
  // keeps the in-flight result intact if D_stall is ever bypassed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    calc_op_d = calc_op_q;
    hl_we_d   = 1'b0;
    accept    = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Req flushes the E-stage instruction, so nothing it carries may
        // launch or write HI/LO.
        if (!md.Req) begin
          hi_we = (md.E_md_op == MD_MTHI);
          lo_we = (md.E_md_op == MD_MTLO);
          if (is_calc_op(md.E_md_op)) begin
            accept    = 1'b1;
            state_d   = ST_BUSY;
            cnt_d     = is_div_op(md.E_md_op) ? DIV_LD : MULT_LD;
            calc_op_d = 2'(md.E_md_op - MD_MULT);
          end
        end
      end
      ST_BUSY: begin
        // Req does not cancel a running calculation; the datapath finishes
        // and the result is still written back.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          hl_we_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Reset abandons any calculation; hl_we is cleared so no late pulse escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      calc_op_q <= CALC_MULT;
      hl_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      calc_op_q <= calc_op_d;
      hl_we_q   <= hl_we_d;
    end
  end

  assign md.cap_en   = accept;
  assign md.calc_op  = calc_op_q;
  assign md.hl_we    = hl_we_q;
  assign md.hi_mt_we = hi_we;
  assign md.lo_mt_we = lo_we;
  assign md.busy     = (state_q == ST_BUSY);
  // An MDU op in D waits while a calculation is running or being launched;
  // release coincides with the hl_we cycle, so HI/LO reads see the new value.
  assign md.D_stall  = md.D_md_use & ((state_q == ST_BUSY) | accept);

  assign state_dbg = state_q;
  assign cnt_dbg   = cnt_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed test of md_ctrl. Each driven cycle pushes a
// hand-computed expected output vector; a monitor on the falling edge pops and
// compares it against the DUT.
// Vector layout: {state, cnt[3:0], cap_en, calc_op[1:0], hl_we, hi_mt_we,
//                 lo_mt_we, busy, D_stall}
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  localparam int W = 13;

  logic clk;
  logic rst;
  md_ctrl_if md ();
  md_state_e state_dbg;
  logic [3:0] cnt_dbg;

  md_ctrl #(
    .MULT_LAT(5),
    .DIV_LAT (10),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .md       (md.slave),
    .state_dbg(state_dbg),
    .cnt_dbg  (cnt_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_viol   = 0;

  function automatic logic [W-1:0] mk(input int st, input int cnt, input int cap,
                                      input int cop, input int hl, input int hi,
                                      input int lo, input int stl);
    logic [W-1:0] v;
    v = {st[0], cnt[3:0], cap[0], cop[1:0], hl[0], hi[0], lo[0], st[0], stl[0]};
    return v;
  endfunction

  // Driver: apply one cycle of inputs just after the rising edge and record
  // what the outputs must be for that cycle.
  task automatic step(input logic r, input logic req, input logic [3:0] op,
                      input logic du, input logic [W-1:0] e, input string nm);
    @(posedge clk);
    #1;
    rst         = r;
    md.Req      = req;
    md.E_md_op  = op;
    md.D_md_use = du;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {(state_dbg == ST_BUSY), cnt_dbg, md.cap_en, md.calc_op, md.hl_we,
             md.hi_mt_we, md.lo_mt_we, md.busy, md.D_stall};
      n_checks++;
      if (act !== e) begin
        n_errors++;
        $display("FAIL %s: got %b required %b (st,cnt,cap,cop,hl,hi,lo,busy,stall)",
                 nm, act, e);
      end
    end
    // Protocol watch: ops 1-6 must never reach E while a calculation runs.
    if (md.busy === 1'b1 && md.E_md_op >= MD_MULT && md.E_md_op <= MD_MTLO) begin
      n_viol++;
      $display("protocol violation: E_md_op=%0d presented while busy (t=%0t)",
               md.E_md_op, $time);
    end
  end

  initial begin
    rst         = 1'b1;
    md.Req      = 1'b0;
    md.E_md_op  = MD_NONE;
    md.D_md_use = 1'b0;

    // Reset state
    step(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "reset0");
    step(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "reset1");
    step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "post_reset");

    // mult: cap_en in cycle 0, busy 1..5, hl_we in 6
    step(0, 0, MD_MULT, 0, mk(0, 0, 1, 0, 0, 0, 0, 0), "mult_accept");
    for (int k = 1; k <= 5; k++)
      step(0, 0, 0, 0, mk(1, 6 - k, 0, 0, 0, 0, 0, 0), "mult_busy");
    step(0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 0), "mult_hl_we");
    step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "mult_after");

    // Reset mid-calculation at cnt=3: everything clears, no late pulse
    step(0, 0, MD_MULT, 0, mk(0, 0, 1, 0, 0, 0, 0, 0), "rstmid_accept");
    step(0, 0, 0, 0, mk(1, 5, 0, 0, 0, 0, 0, 0), "rstmid_c5");
    step(0, 0, 0, 0, mk(1, 4, 0, 0, 0, 0, 0, 0), "rstmid_c4");
    step(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "rstmid_assert");
    step(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "rstmid_hold");
    for (int k = 0; k < 8; k++)
      step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "rstmid_no_pulse");

    // div with mflo waiting in D: stall 0..10, release and hl_we in 11
    step(0, 0, MD_DIV, 1, mk(0, 0, 1, 0, 0, 0, 0, 1), "div_accept_stall");
    for (int k = 1; k <= 10; k++)
      step(0, 0, 0, 1, mk(1, 11 - k, 0, 2, 0, 0, 0, 1), "div_busy_stall");
    step(0, 0, 0, 1, mk(0, 0, 0, 2, 1, 0, 0, 0), "div_release");
    step(0, 0, MD_MFLO, 0, mk(0, 0, 0, 2, 0, 0, 0, 0), "mflo_in_e");

    // Req in the accept cycle suppresses launch and mt writes
    step(0, 1, MD_MULTU, 1, mk(0, 0, 0, 2, 0, 0, 0, 0), "req_suppress");
    step(0, 0, 0, 0, mk(0, 0, 0, 2, 0, 0, 0, 0), "req_idle1");
    step(0, 0, 0, 0, mk(0, 0, 0, 2, 0, 0, 0, 0), "req_idle2");
    step(0, 1, MD_MTHI, 0, mk(0, 0, 0, 2, 0, 0, 0, 0), "req_mthi");

    // divu with Req in cycle 4: runs to completion
    step(0, 0, MD_DIVU, 0, mk(0, 0, 1, 2, 0, 0, 0, 0), "divu_accept");
    for (int k = 1; k <= 10; k++)
      step(0, (k == 4), 0, 0, mk(1, 11 - k, 0, 3, 0, 0, 0, 0), "divu_busy");
    step(0, 0, 0, 0, mk(0, 0, 0, 3, 1, 0, 0, 0), "divu_hl_we");
    step(0, 0, 0, 0, mk(0, 0, 0, 3, 0, 0, 0, 0), "divu_after");

    // mt writes while idle; codes with no effect
    step(0, 0, MD_MTLO, 0, mk(0, 0, 0, 3, 0, 0, 1, 0), "mtlo_idle");
    step(0, 0, MD_MTHI, 0, mk(0, 0, 0, 3, 0, 1, 0, 0), "mthi_idle");
    step(0, 0, 4'd15, 1, mk(0, 0, 0, 3, 0, 0, 0, 0), "code15");
    step(0, 0, MD_MFHI, 0, mk(0, 0, 0, 3, 0, 0, 0, 0), "mfhi_in_e");

    // mthi forced during BUSY: ignored, counter continues; then a new
    // multu accepted in the same cycle as the hl_we pulse
    step(0, 0, MD_MULT, 0, mk(0, 0, 1, 3, 0, 0, 0, 0), "viol_accept");
    step(0, 0, 0, 0, mk(1, 5, 0, 0, 0, 0, 0, 0), "viol_c5");
    step(0, 0, MD_MTHI, 0, mk(1, 4, 0, 0, 0, 0, 0, 0), "viol_mthi_busy");
    step(0, 0, 0, 0, mk(1, 3, 0, 0, 0, 0, 0, 0), "viol_c3");
    step(0, 0, 0, 0, mk(1, 2, 0, 0, 0, 0, 0, 0), "viol_c2");
    step(0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0), "viol_c1");
    step(0, 0, MD_MULTU, 0, mk(0, 0, 1, 0, 1, 0, 0, 0), "hl_we_plus_accept");
    for (int k = 1; k <= 5; k++)
      step(0, 0, 0, 0, mk(1, 6 - k, 0, 1, 0, 0, 0, 0), "multu_busy");
    step(0, 0, 0, 0, mk(0, 0, 0, 1, 1, 0, 0, 0), "multu_hl_we");
    step(0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0), "multu_after");

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    n_checks++;
    if (n_viol != 1) begin
      n_errors++;
      $display("FAIL protocol_flag: got %0d violations required 1", n_viol);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
